// File: rtl/shift_add_sequencer.sv
// -----------------------------------------------------------------------------
// shift_add_sequencer
//
// Microprogrammed 4x4 shift-and-add multiplier. The block drives a microprogram
// address (count) to an external control ROM and executes the op/val word the
// ROM returns in the same cycle. A normal program is:
//   LDX, LDY, then ITERS x (ADD, SHF), then STR
// which takes 3 + 2*ITERS clock cycles in RUN.
//
// Ports
//   clk    : single clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request to run one program (sampled in IDLE only)
//   op     : control word from the ROM for the current count
//   val    : operand value from the ROM for the current count
//   count  : microprogram address to the ROM (registered)
//   prod   : product of the last completed program (registered)
//   busy   : high while a program is executing (registered)
//   done   : one-cycle pulse in the cycle prod is updated (registered)
//   err    : sticky illegal-op flag, cleared by reset or an accepted start
// -----------------------------------------------------------------------------
module shift_add_sequencer #(
  parameter int ITERS = 4  // number of ADD/SHF passes, 1..4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [3:0] val,
  output logic [3:0] count,
  output logic [7:0] prod,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] OP_LDX = 4'd0;
  localparam logic [3:0] OP_LDY = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SHF = 4'd3;
  localparam logic [3:0] OP_STR = 4'd4;

  // Last value of the iteration counter before the program moves on to STR.
  localparam logic [1:0] I_LAST = 2'(ITERS - 1);

  state_t     state_r;
  logic [7:0] x_r;      // multiplicand, shifted left each pass
  logic [3:0] y_r;      // multiplier, shifted right each pass
  logic [7:0] z_r;      // accumulator
  logic [1:0] i_r;      // iteration counter
  logic [3:0] count_r;
  logic [7:0] prod_r;
  logic       busy_r;
  logic       done_r;
  logic       err_r;

  // Conditional accumulate: adds the shifted multiplicand when the current
  // multiplier LSB is set; the sum wraps modulo 256.
  function automatic logic [7:0] add_step(
    input logic [7:0] z,
    input logic [7:0] x,
    input logic       y_lsb
  );
    logic [7:0] sum;
    if (y_lsb) begin
      sum = z + x;
    end else begin
      sum = z;
    end
    return sum;
  endfunction

  // Sequencer: state, datapath registers and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      x_r     <= 8'd0;
      y_r     <= 4'd0;
      z_r     <= 8'd0;
      i_r     <= 2'd0;
      count_r <= 4'd0;
      prod_r  <= 8'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only STR raises it again.
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          count_r <= 4'd0;
          if (start) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            err_r   <= 1'b0;
            i_r     <= 2'd0;
          end
        end
        RUN: begin
          case (op)
            OP_LDX: begin
              x_r     <= {4'b0000, val};
              y_r     <= 4'd0;
              z_r     <= 8'd0;
              count_r <= 4'd1;
            end
            OP_LDY: begin
              y_r     <= val;
              count_r <= 4'd2;
            end
            OP_ADD: begin
              z_r     <= add_step(z_r, x_r, y_r[0]);
              count_r <= 4'd3;
            end
            OP_SHF: begin
              y_r <= {1'b0, y_r[3:1]};
              x_r <= {x_r[6:0], 1'b0};
              if (i_r < I_LAST) begin
                i_r     <= i_r + 2'd1;
                count_r <= 4'd2;
              end else begin
                i_r     <= 2'd0;
                count_r <= 4'd4;
              end
            end
            OP_STR: begin
              prod_r  <= z_r;
              done_r  <= 1'b1;
              state_r <= IDLE;
              count_r <= 4'd0;
              busy_r  <= 1'b0;
            end
            default: begin
              // Illegal op: abandon the program without touching prod.
              err_r   <= 1'b1;
              state_r <= IDLE;
              count_r <= 4'd0;
              busy_r  <= 1'b0;
            end
          endcase
        end
        default: begin
          state_r <= IDLE;
          count_r <= 4'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_r;
  assign prod  = prod_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign err   = err_r;

endmodule

// File: tb/tb_shift_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_add_sequencer
//
// Bench for shift_add_sequencer. A behavioural control ROM returns the
// standard multiply microprogram (optionally with one word replaced by an
// illegal op). Expected products come from plain arithmetic on the operands
// and the expected address trace is built from the program shape.
// -----------------------------------------------------------------------------
module tb_shift_add_sequencer;

  localparam int ITERS   = 4;
  localparam int RUN_LEN = 3 + 2 * ITERS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] op;
  logic [3:0] val;
  logic [3:0] count;
  logic [7:0] prod;
  logic       busy;
  logic       done;
  logic       err;

  // ROM contents and fault override
  logic [3:0] rom_x;
  logic [3:0] rom_y;
  logic       bad_en;
  logic [3:0] bad_count;
  logic [3:0] bad_op;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Observations from the most recent run_program call
  int         seq_q[$];
  int         busy_cnt;
  int         done_edge;
  int         done_cnt;
  logic [7:0] prod_at_done;
  logic [3:0] count_at_done;
  logic       busy_at_done;

  always #5 clk = ~clk;

  shift_add_sequencer #(.ITERS(ITERS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .val   (val),
    .count (count),
    .prod  (prod),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  // Control ROM: standard multiply microprogram addressed by count.
  always_comb begin
    op  = 4'hF;
    val = 4'h0;
    case (count)
      4'd0: begin op = 4'd0; val = rom_x; end
      4'd1: begin op = 4'd1; val = rom_y; end
      4'd2: op = 4'd2;
      4'd3: op = 4'd3;
      4'd4: op = 4'd4;
      default: op = 4'hF;
    endcase
    if (bad_en && count == bad_count) op = bad_op;
  end

  function automatic int exp_prod(input int x, input int y);
    return (x * (y % (1 << ITERS))) % 256;
  endfunction

  // True when seq_q equals the address trace 0,1,(2,3)*ITERS,4.
  function automatic bit seq_matches();
    int exp_q[$];
    exp_q.push_back(0);
    exp_q.push_back(1);
    for (int i = 0; i < ITERS; i++) begin
      exp_q.push_back(2);
      exp_q.push_back(3);
    end
    exp_q.push_back(4);
    if (seq_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (seq_q[i] != exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge and observe `window` further edges.
  task automatic run_program(input logic [3:0] x, input logic [3:0] y, input int window);
    rom_x = x;
    rom_y = y;
    start = 1'b1;
    step();
    start = 1'b0;
    seq_q.delete();
    busy_cnt      = 0;
    done_edge     = -1;
    done_cnt      = 0;
    prod_at_done  = 8'hxx;
    count_at_done = 4'hx;
    busy_at_done  = 1'bx;
    for (int k = 1; k <= window; k++) begin
      if (busy === 1'b1) begin
        seq_q.push_back(int'(count));
        busy_cnt++;
      end
      step();
      if (done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge     = k;
          prod_at_done  = prod;
          count_at_done = count;
          busy_at_done  = busy;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({count, prod, busy, done, err} !== 15'd0) begin
      $display("FAIL reset_async: got count=%0d prod=%0d busy=%b done=%b err=%b, want all 0",
               count, prod, busy, done, err);
    end else pass_cnt++;
    start = 1'b1;
    step();
    step();
    total_cnt++;
    if ({count, prod, busy, done, err} !== 15'd0) begin
      $display("FAIL reset_hold: got count=%0d prod=%0d busy=%b done=%b err=%b, want all 0",
               count, prod, busy, done, err);
    end else pass_cnt++;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    total_cnt++;
    if (busy !== 1'b0 || count !== 4'd0) begin
      $display("FAIL idle_after_reset: got busy=%b count=%0d, want busy=0 count=0", busy, count);
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    run_program(4'd3, 4'd5, RUN_LEN + 3);
    total_cnt++;
    if (!seq_matches()) begin
      $display("FAIL basic_seq: got %p, want 0,1,(2,3)x%0d,4", seq_q, ITERS);
    end else pass_cnt++;
    total_cnt++;
    if (done_edge != RUN_LEN) begin
      $display("FAIL basic_latency: got done after edge %0d, want %0d", done_edge, RUN_LEN);
    end else pass_cnt++;
    total_cnt++;
    if (done_cnt != 1) begin
      $display("FAIL basic_done_pulses: got %0d, want 1", done_cnt);
    end else pass_cnt++;
    total_cnt++;
    if (prod_at_done !== 8'(exp_prod(3, 5))) begin
      $display("FAIL basic_prod: got %0d, want %0d", prod_at_done, exp_prod(3, 5));
    end else pass_cnt++;
    total_cnt++;
    if (count_at_done !== 4'd0 || busy_at_done !== 1'b0) begin
      $display("FAIL basic_done_cycle: got count=%0d busy=%b, want count=0 busy=0",
               count_at_done, busy_at_done);
    end else pass_cnt++;
    total_cnt++;
    if (busy_cnt != RUN_LEN) begin
      $display("FAIL basic_busy_len: got %0d cycles, want %0d", busy_cnt, RUN_LEN);
    end else pass_cnt++;
    total_cnt++;
    if (err !== 1'b0) begin
      $display("FAIL basic_err: got %b, want 0", err);
    end else pass_cnt++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [3:0] x;
      logic [3:0] y;
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      run_program(x, y, RUN_LEN + 3);
      total_cnt++;
      if (prod !== 8'(exp_prod(int'(x), int'(y))) || done_cnt != 1 || done_edge != RUN_LEN) begin
        $display("FAIL random_prod x=%0d y=%0d: got prod=%0d dones=%0d edge=%0d, want prod=%0d dones=1 edge=%0d",
                 x, y, prod, done_cnt, done_edge, exp_prod(int'(x), int'(y)), RUN_LEN);
      end else pass_cnt++;
    end
  endtask

  task automatic test_max();
    run_program(4'd15, 4'd15, RUN_LEN + 3);
    total_cnt++;
    if (prod_at_done !== 8'd225 || err !== 1'b0) begin
      $display("FAIL max_operands: got prod=%0d err=%b, want prod=225 err=0", prod_at_done, err);
    end else pass_cnt++;
  endtask

  task automatic test_zero_y();
    run_program(4'd9, 4'd0, RUN_LEN + 3);
    total_cnt++;
    if (prod_at_done !== 8'd0 || done_cnt != 1) begin
      $display("FAIL zero_y: got prod=%0d dones=%0d, want prod=0 dones=1", prod_at_done, done_cnt);
    end else pass_cnt++;
    step();
    step();
    step();
    total_cnt++;
    if (prod !== 8'd0 || busy !== 1'b0) begin
      $display("FAIL prod_hold_idle: got prod=%0d busy=%b, want prod=0 busy=0", prod, busy);
    end else pass_cnt++;
  endtask

  task automatic test_illegal();
    bit stable_ok;
    run_program(4'd7, 4'd3, RUN_LEN + 3);
    bad_en    = 1'b1;
    bad_count = 4'd3;
    bad_op    = 4'($urandom_range(5, 15));
    rom_x = 4'd3;
    rom_y = 4'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    total_cnt++;
    if (count !== 4'd3 || err !== 1'b0) begin
      $display("FAIL illegal_pre: got count=%0d err=%b, want count=3 err=0", count, err);
    end else pass_cnt++;
    step();
    total_cnt++;
    if (err !== 1'b1 || busy !== 1'b0 || count !== 4'd0 || done !== 1'b0 || prod !== 8'd21) begin
      $display("FAIL illegal_op %0h: got err=%b busy=%b count=%0d done=%b prod=%0d, want err=1 busy=0 count=0 done=0 prod=21",
               bad_op, err, busy, count, done, prod);
    end else pass_cnt++;
    stable_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (err !== 1'b1 || done !== 1'b0 || prod !== 8'd21) stable_ok = 1'b0;
    end
    total_cnt++;
    if (!stable_ok) begin
      $display("FAIL illegal_sticky: got err=%b done=%b prod=%0d, want err=1 done=0 prod=21", err, done, prod);
    end else pass_cnt++;
    bad_en = 1'b0;
    run_program(4'd3, 4'd5, RUN_LEN + 3);
    total_cnt++;
    if (err !== 1'b0 || prod !== 8'd15) begin
      $display("FAIL illegal_clear: got err=%b prod=%0d, want err=0 prod=15", err, prod);
    end else pass_cnt++;
  endtask

  task automatic test_async_reset();
    bit quiet_ok;
    rom_x = 4'd2;
    rom_y = 4'd6;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    total_cnt++;
    if (busy !== 1'b1 || count !== 4'd3) begin
      $display("FAIL midrun_state: got busy=%b count=%0d, want busy=1 count=3", busy, count);
    end else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({count, prod, busy, done, err} !== 15'd0) begin
      $display("FAIL midrun_reset: got count=%0d prod=%0d busy=%b done=%b err=%b, want all 0",
               count, prod, busy, done, err);
    end else pass_cnt++;
    quiet_ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0 || prod !== 8'd0) quiet_ok = 1'b0;
    end
    total_cnt++;
    if (!quiet_ok) begin
      $display("FAIL reset_quiet: got done=%b busy=%b prod=%0d, want 0/0/0", done, busy, prod);
    end else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    run_program(4'd3, 4'd5, RUN_LEN + 3);
    total_cnt++;
    if (prod_at_done !== 8'd15 || done_edge != RUN_LEN || !seq_matches()) begin
      $display("FAIL post_reset_run: got prod=%0d edge=%0d seq=%p, want prod=15 edge=%0d full trace",
               prod_at_done, done_edge, seq_q, RUN_LEN);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int  dq[$];
    bit  prev_done;
    rom_x = 4'd3;
    rom_y = 4'd5;
    start = 1'b1;
    step();
    prev_done = 1'b0;
    for (int k = 1; k <= 3 * (RUN_LEN + 1); k++) begin
      step();
      if (prev_done) begin
        total_cnt++;
        if (busy !== 1'b1 || count !== 4'd0) begin
          $display("FAIL b2b_restart edge %0d: got busy=%b count=%0d, want busy=1 count=0", k, busy, count);
        end else pass_cnt++;
      end
      prev_done = (done === 1'b1);
      if (prev_done) begin
        dq.push_back(k);
        total_cnt++;
        if (prod !== 8'd15 || busy !== 1'b0) begin
          $display("FAIL b2b_done edge %0d: got prod=%0d busy=%b, want prod=15 busy=0", k, prod, busy);
        end else pass_cnt++;
      end
    end
    start = 1'b0;
    for (int k = 0; k < RUN_LEN + 2; k++) step();
    total_cnt++;
    if (dq.size() != 3 ||
        dq[0] != RUN_LEN || dq[1] != 2 * RUN_LEN + 1 || dq[2] != 3 * RUN_LEN + 2) begin
      $display("FAIL b2b_spacing: got done edges %p, want %0d %0d %0d",
               dq, RUN_LEN, 2 * RUN_LEN + 1, 3 * RUN_LEN + 2);
    end else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      $display("FAIL b2b_drain: got busy=%b err=%b, want 0/0", busy, err);
    end else pass_cnt++;
  endtask

  initial begin
    rst_n     = 1'b1;
    start     = 1'b0;
    rom_x     = 4'd0;
    rom_y     = 4'd0;
    bad_en    = 1'b0;
    bad_count = 4'd0;
    bad_op    = 4'hF;
    test_reset();
    test_basic();
    test_random();
    test_max();
    test_zero_y();
    test_illegal();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/shift_add_sequencer.md
SHIFT_ADD_SEQUENCER -- requirements
Module: shift_add_sequencer

Interface
REQ-001 SHALL have parameter ITERS, default 4, giving the number of ADD/SHF passes (valid range 1..4).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to run one multiply program.
REQ-005 SHALL have port op, input, 4, control word returned by the control ROM for the current count.
REQ-006 SHALL have port val, input, 4, operand value returned by the control ROM for the current count.
REQ-007 SHALL have port count, output, 4, microprogram address driven to the control ROM.
REQ-008 SHALL have port prod, output, 8, registered product of the last completed program.
REQ-009 SHALL have port busy, output, 1, high while a program is executing.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when prod is updated.
REQ-011 SHALL have port err, output, 1, sticky flag set on an illegal op.

Function
REQ-012 SHALL implement FSM states IDLE and RUN; op/val are combinational from count and are sampled in the same cycle.
REQ-013 SHALL hold internal registers X (8b multiplicand), Y (4b multiplier), Z (8b accumulator), and I (iteration counter, 0..ITERS-1).
REQ-014 SHALL, in IDLE, hold count at 0 and move to RUN on a rising edge with start=1, clearing err and I, with busy=1 from the next cycle.
REQ-015 SHALL ignore start while in RUN.
REQ-016 SHALL, in RUN, execute exactly one op per clock, as defined in REQ-017 to REQ-021.
REQ-017 SHALL decode op 0000 (LDX) as: X<={0000,val}, Y<=0, Z<=0, count<=1.
REQ-018 SHALL decode op 0001 (LDY) as: Y<=val, count<=2.
REQ-019 SHALL decode op 0010 (ADD) as: if Y[0], Z<=Z+X modulo 256, else Z held; count<=3.
REQ-020 SHALL decode op 0011 (SHF) as: Y<=Y>>1 (zero fill), X<=X<<1 (bit 7 dropped).
- If I<ITERS-1: I<=I+1, count<=2.
- Otherwise: I<=0, count<=4.
REQ-021 SHALL decode op 0100 (STR) as: prod<=Z, done=1 for exactly one cycle, state<=IDLE, count<=0, busy=0.
REQ-022 SHALL treat any other op code as illegal:
- err<=1, state<=IDLE, count<=0.
- prod not updated, done not asserted.
REQ-023 SHALL take 3+2*ITERS RUN cycles per program; for ITERS=4, done is high in the cycle after the 11th rising edge following the start-sampling edge.
REQ-024 SHALL hold prod and err stable between programs; err is cleared only by reset or by an accepted start.
REQ-025 SHALL hold X, Y, Z, and I unchanged in IDLE.

Reset
REQ-026 SHALL, while rst_n=0, immediately force state=IDLE, count=0, prod=0, busy=0, done=0, err=0, and X=Y=Z=I=0, independent of clk.
REQ-027 SHALL, on reset asserted mid-program, abandon the program with no done pulse and no prod update; the first start after release runs a full program from count 0.

Verification
REQ-028 SHALL pass: ROM X=3, Y=5, ITERS=4, start pulse -> count sequence 0,1,2,3,2,3,2,3,2,3,4,0; prod=15; done single pulse at cycle 11; busy high for 11 cycles.
REQ-029 SHALL pass: ROM X=15, Y=15 -> prod=225, no overflow, err=0.
REQ-030 SHALL pass: ROM Y=0, X=9 -> prod=0, done pulses, Z never changes after LDX.
REQ-031 SHALL pass: ROM returns op=1111 at count 3 -> err=1 after that edge, count=0, busy=0, no done, prod keeps the prior value; the next start clears err.
REQ-032 SHALL pass: rst_n driven low at the 6th RUN cycle, asynchronously between edges -> all outputs 0 immediately; a new start after release gives prod=15 for X=3, Y=5.
REQ-033 SHALL pass: start held high continuously -> programs run back-to-back with one IDLE cycle between done and the next count=0 RUN cycle; start inside RUN has no effect.
